// File: rtl/nnalloc_pkg.sv
// Shared widths and bit-vector helpers for the output allocator.
// Round-robin arbitration is selected by defining NNALLOC_ROUND_ROBIN_EN.
package nnalloc_pkg;

    // Helpers work on a fixed-width container; channel counts must stay below this.
    localparam int MAX_CH = 32;

    localparam int DEFAULT_N = 5;
    localparam int DEFAULT_M = 5;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_IN  = idx_width(DEFAULT_N);
    localparam int IDX_W_OUT = idx_width(DEFAULT_M);

    // Rotate a one-hot vector left by one position within the low n bits.
    function automatic logic [MAX_CH-1:0] onehot_rotate(input logic [MAX_CH-1:0] v,
                                                        input int n);
        logic [MAX_CH-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < n && v[k]) begin
                if (k + 1 == n) r[0] = 1'b1;
                else            r[k+1] = 1'b1;
            end
        end
        return r;
    endfunction

    // One-hot of the first set bit of vec, scanning upward (with wrap) from the
    // one-hot start position, restricted to the low n bits.
    function automatic logic [MAX_CH-1:0] first_set_from(input logic [MAX_CH-1:0] vec,
                                                         input logic [MAX_CH-1:0] start,
                                                         input int n);
        logic [MAX_CH-1:0] r;
        logic              found;
        int                s;
        int                idx;
        r     = '0;
        found = 1'b0;
        s     = 0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < n && start[k]) s = k;
        end
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < n && !found) begin
                idx = s + k;
                if (idx >= n) idx = idx - n;
                if (vec[idx]) begin
                    r[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_rr_arbiter.sv
// Per-output arbiter: picks one requesting input while enabled. Rotating pointer
// when NNALLOC_ROUND_ROBIN_EN is defined, lowest-index priority otherwise.
module nn_rr_arbiter
    import nnalloc_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] pick
);

    logic [MAX_CH-1:0] req_wide;
    logic [MAX_CH-1:0] pick_wide;

    assign req_wide = MAX_CH'(req);

`ifdef NNALLOC_ROUND_ROBIN_EN
    // ptr_reg is one-hot: the input with highest priority on the next grant.
    logic [N-1:0]      ptr_reg;
    logic [MAX_CH-1:0] ptr_next_wide;
    logic              unused_ok;

    always_comb begin
        pick_wide     = first_set_from(req_wide, MAX_CH'(ptr_reg), N);
        ptr_next_wide = onehot_rotate(MAX_CH'(pick), N);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= N'(1);
        end else if (|pick) begin
            ptr_reg <= ptr_next_wide[N-1:0];
        end
    end

    assign unused_ok = &{1'b0, pick_wide, ptr_next_wide};
`else
    logic unused_ok;

    always_comb begin
        pick_wide = first_set_from(req_wide, MAX_CH'(1), N);
    end

    assign unused_ok = &{1'b0, pick_wide, clk, rst};
`endif

    assign pick = enable ? pick_wide[N-1:0] : '0;

endmodule

// File: rtl/nn_output_allocator.sv
// Packet-level N-in/M-out output allocator; holds each pairing until TLAST.
// Build option NNALLOC_ROUND_ROBIN_EN selects rotating per-output priority.
module nn_output_allocator
    import nnalloc_pkg::*;
#(
    parameter int CHANNEL_NUMBER_IN  = 5,
    parameter int CHANNEL_NUMBER_OUT = 5
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [CHANNEL_NUMBER_IN-1:0]                         in_tvalid,
    input  logic [CHANNEL_NUMBER_IN-1:0]                         in_tready,
    input  logic [CHANNEL_NUMBER_IN-1:0]                         in_tlast,
    input  logic [CHANNEL_NUMBER_IN-1:0][CHANNEL_NUMBER_OUT-1:0] selector,
    output logic [CHANNEL_NUMBER_OUT-1:0][CHANNEL_NUMBER_IN-1:0] out_grant,
    output logic [CHANNEL_NUMBER_IN-1:0][CHANNEL_NUMBER_OUT-1:0] in_grant,
    output logic [CHANNEL_NUMBER_OUT-1:0]                        out_busy
);

    localparam int N = CHANNEL_NUMBER_IN;
    localparam int M = CHANNEL_NUMBER_OUT;

    logic [M-1:0][N-1:0] alloc_reg;
    logic [M-1:0][N-1:0] alloc_next;
    logic [M-1:0][N-1:0] pick_all;
    logic [N-1:0]        in_alloc;
    logic [N-1:0]        req;
    logic [N-1:0]        rel;

    always_comb begin
        in_alloc = '0;
        req      = '0;
        rel      = '0;
        for (int i = 0; i < N; i++) begin
            for (int o = 0; o < M; o++) begin
                in_alloc[i] = in_alloc[i] | alloc_reg[o][i];
            end
            req[i] = in_tvalid[i] & ~in_alloc[i] & (|selector[i]);
            rel[i] = in_tvalid[i] & in_tready[i] & in_tlast[i] & in_alloc[i];
        end
    end

    // Outputs are chained in ascending order; each one sees the inputs already
    // claimed by lower-index outputs in this same pass.
    for (genvar gi = 0; gi < M; gi++) begin : gen_out
        logic [N-1:0] claimed_in;
        logic [N-1:0] claimed_out;
        logic [N-1:0] req_col;
        logic [N-1:0] pick;

        if (gi == 0) begin : gen_first
            assign claimed_in = '0;
        end else begin : gen_chain
            assign claimed_in = gen_out[gi-1].claimed_out;
        end

        always_comb begin
            req_col = '0;
            for (int i = 0; i < N; i++) begin
                req_col[i] = req[i] & selector[i][gi] & ~claimed_in[i];
            end
        end

        nn_rr_arbiter #(.N(N)) u_arb (
            .clk    (clk),
            .rst    (rst),
            .req    (req_col),
            .enable (~out_busy[gi]),
            .pick   (pick)
        );

        assign claimed_out  = claimed_in | pick;
        assign pick_all[gi] = pick;
        assign out_busy[gi] = |alloc_reg[gi];
    end

    // A pick only ever lands on a free output and an unallocated input, so it
    // never collides with a release in the same edge.
    always_comb begin
        alloc_next = '0;
        for (int o = 0; o < M; o++) begin
            for (int i = 0; i < N; i++) begin
                alloc_next[o][i] = (alloc_reg[o][i] & ~rel[i]) | pick_all[o][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_reg <= '0;
        end else begin
            alloc_reg <= alloc_next;
        end
    end

    always_comb begin
        in_grant = '0;
        for (int i = 0; i < N; i++) begin
            for (int o = 0; o < M; o++) begin
                in_grant[i][o] = alloc_reg[o][i];
            end
        end
    end

    assign out_grant = alloc_reg;

endmodule

// File: tb/tb_nn_output_allocator.sv
// Scoreboard bench for nn_output_allocator (N = M = 5): expected grant maps are
// queued as each cycle is driven and compared against the post-edge outputs.
module tb_nn_output_allocator;

    typedef logic [4:0][4:0] mat_t;
    typedef struct {
        string      name;
        mat_t       og;
        mat_t       ig;
        logic [4:0] busy;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] in_tvalid = '0;
    logic [4:0] in_tready = '0;
    logic [4:0] in_tlast  = '0;
    mat_t       selector  = '0;
    mat_t       out_grant;
    mat_t       in_grant;
    logic [4:0] out_busy;

    snap_t exp_q[$];
    snap_t obs_q[$];
    int    passed = 0;
    int    total  = 0;

    nn_output_allocator #(
        .CHANNEL_NUMBER_IN  (5),
        .CHANNEL_NUMBER_OUT (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_tvalid (in_tvalid),
        .in_tready (in_tready),
        .in_tlast  (in_tlast),
        .selector  (selector),
        .out_grant (out_grant),
        .in_grant  (in_grant),
        .out_busy  (out_busy)
    );

    always #5 clk = ~clk;

    function automatic mat_t pr(input int o, input int i);
        mat_t m;
        m = '0;
        m[o][i] = 1'b1;
        return m;
    endfunction

    // Drive one cycle, queue the expected post-edge maps, then snapshot the DUT.
    task automatic drive(input string name, input logic r, input logic [4:0] v,
                         input logic [4:0] rdy, input logic [4:0] lst,
                         input mat_t sel, input mat_t og);
        snap_t e;
        snap_t ob;
        e.name = name;
        e.og   = og;
        e.ig   = '0;
        e.busy = '0;
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                if (og[o][i]) begin
                    e.ig[i][o] = 1'b1;
                    e.busy[o]  = 1'b1;
                end
            end
        end
        rst       = r;
        in_tvalid = v;
        in_tready = rdy;
        in_tlast  = lst;
        selector  = sel;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ob.name = name;
        ob.og   = out_grant;
        ob.ig   = in_grant;
        ob.busy = out_busy;
        obs_q.push_back(ob);
    endtask

    task automatic test_reset;
        mat_t  sel;
        snap_t e;
        snap_t ob;
        sel = '0;
        sel[2] = 5'b00100;
        drive("reset",      1'b1, 5'b00000, 5'b00000, 5'b00000, sel, '0);
        drive("grant_in2",  1'b0, 5'b00100, 5'b00000, 5'b00000, sel, pr(2, 2));
        drive("hold_in2",   1'b0, 5'b00100, 5'b00100, 5'b00000, sel, pr(2, 2));
        drive("release_2",  1'b0, 5'b00100, 5'b00100, 5'b00100, sel, '0);
        drive("idle",       1'b0, 5'b00000, 5'b00000, 5'b00000, sel, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ob = obs_q.pop_front();
            total++;
            if (ob.og !== e.og) $display("FAIL reset/%s out_grant got %h need %h", e.name, ob.og, e.og);
            else passed++;
            total++;
            if (ob.ig !== e.ig) $display("FAIL reset/%s in_grant got %h need %h", e.name, ob.ig, e.ig);
            else passed++;
            total++;
            if (ob.busy !== e.busy) $display("FAIL reset/%s out_busy got %b need %b", e.name, ob.busy, e.busy);
            else passed++;
        end
    endtask

    task automatic test_contention;
        mat_t       sel;
        mat_t       win6;
        logic [4:0] rel6;
        snap_t      e;
        snap_t      ob;
        sel = '0;
        sel[0] = 5'b00010;
        sel[3] = 5'b00010;
`ifdef NNALLOC_ROUND_ROBIN_EN
        win6 = pr(1, 3);
        rel6 = 5'b01000;
`else
        win6 = pr(1, 0);
        rel6 = 5'b00001;
`endif
        drive("reset",     1'b1, 5'b00000, 5'b00000, 5'b00000, sel, '0);
        drive("first",     1'b0, 5'b01001, 5'b00000, 5'b00000, sel, pr(1, 0));
        drive("rel0",      1'b0, 5'b01001, 5'b00001, 5'b00001, sel, '0);
        drive("then3",     1'b0, 5'b01000, 5'b00000, 5'b00000, sel, pr(1, 3));
        drive("rel3",      1'b0, 5'b01001, 5'b01000, 5'b01000, sel, '0);
        drive("second",    1'b0, 5'b01001, 5'b00000, 5'b00000, sel, pr(1, 0));
        drive("rel0b",     1'b0, 5'b01001, 5'b00001, 5'b00001, sel, '0);
        drive("third",     1'b0, 5'b01001, 5'b00000, 5'b00000, sel, win6);
        drive("rel_win",   1'b0, 5'b00000 | rel6, rel6, rel6, sel, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ob = obs_q.pop_front();
            total++;
            if (ob.og !== e.og) $display("FAIL contention/%s out_grant got %h need %h", e.name, ob.og, e.og);
            else passed++;
            total++;
            if (ob.ig !== e.ig) $display("FAIL contention/%s in_grant got %h need %h", e.name, ob.ig, e.ig);
            else passed++;
        end
    endtask

    task automatic test_partial_busy;
        mat_t  sel;
        snap_t e;
        snap_t ob;
        sel = '0;
        sel[0] = 5'b00001;
        sel[1] = 5'b00011;
        drive("reset",      1'b1, 5'b00000, 5'b00000, 5'b00000, sel, '0);
        drive("take_out0",  1'b0, 5'b00001, 5'b00000, 5'b00000, sel, pr(0, 0));
        drive("in1_to_o1",  1'b0, 5'b00011, 5'b00000, 5'b00000, sel, pr(0, 0) | pr(1, 1));
        drive("hold_both",  1'b0, 5'b00011, 5'b00000, 5'b00000, sel, pr(0, 0) | pr(1, 1));
        drive("rel0",       1'b0, 5'b00011, 5'b00001, 5'b00001, sel, pr(1, 1));
        drive("no_second",  1'b0, 5'b00010, 5'b00000, 5'b00000, sel, pr(1, 1));
        drive("rel1",       1'b0, 5'b00010, 5'b00010, 5'b00010, sel, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ob = obs_q.pop_front();
            total++;
            if (ob.og !== e.og) $display("FAIL partial/%s out_grant got %h need %h", e.name, ob.og, e.og);
            else passed++;
            total++;
            if (ob.busy !== e.busy) $display("FAIL partial/%s out_busy got %b need %b", e.name, ob.busy, e.busy);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        mat_t  sel;
        snap_t e;
        snap_t ob;
        sel = '0;
        sel[0] = 5'b00011;
        sel[1] = 5'b00011;
        sel[2] = 5'b00100;
        sel[3] = 5'b01000;
        drive("reset",       1'b1, 5'b00000, 5'b00000, 5'b00000, sel, '0);
        drive("pair_grant",  1'b0, 5'b00011, 5'b00000, 5'b00000, sel, pr(0, 0) | pr(1, 1));
        drive("rel_and_new", 1'b0, 5'b00111, 5'b00001, 5'b00001, sel, pr(1, 1) | pr(2, 2));
        drive("rel_1_2",     1'b0, 5'b00110, 5'b00110, 5'b00110, sel, '0);
        drive("tlast_unall", 1'b0, 5'b01000, 5'b01000, 5'b01000, sel, pr(3, 3));
        drive("rel3",        1'b0, 5'b01000, 5'b01000, 5'b01000, sel, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ob = obs_q.pop_front();
            total++;
            if (ob.og !== e.og) $display("FAIL b2b/%s out_grant got %h need %h", e.name, ob.og, e.og);
            else passed++;
            total++;
            if (ob.ig !== e.ig) $display("FAIL b2b/%s in_grant got %h need %h", e.name, ob.ig, e.ig);
            else passed++;
        end
    endtask

    task automatic test_packet;
        mat_t  sel;
        mat_t  sel_chg;
        snap_t e;
        snap_t ob;
        sel = '0;
        sel[4] = 5'b10000;
        sel_chg = '0;
        sel_chg[4] = 5'b01000;
        drive("reset",     1'b1, 5'b00000, 5'b00000, 5'b00000, sel,     '0);
        drive("grant4",    1'b0, 5'b10000, 5'b00000, 5'b00000, sel,     pr(4, 4));
        drive("beat1",     1'b0, 5'b10000, 5'b10000, 5'b00000, sel_chg, pr(4, 4));
        drive("beat2",     1'b0, 5'b10000, 5'b10000, 5'b00000, sel_chg, pr(4, 4));
        drive("last_stall",1'b0, 5'b10000, 5'b00000, 5'b10000, sel_chg, pr(4, 4));
        drive("last_beat", 1'b0, 5'b10000, 5'b10000, 5'b10000, sel_chg, '0);
        drive("no_valid",  1'b0, 5'b00000, 5'b00000, 5'b00000, sel_chg, '0);
        drive("new_sel",   1'b0, 5'b10000, 5'b00000, 5'b00000, sel_chg, pr(3, 4));
        drive("rel4",      1'b0, 5'b10000, 5'b10000, 5'b10000, sel_chg, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ob = obs_q.pop_front();
            total++;
            if (ob.og !== e.og) $display("FAIL packet/%s out_grant got %h need %h", e.name, ob.og, e.og);
            else passed++;
            total++;
            if (ob.busy !== e.busy) $display("FAIL packet/%s out_busy got %b need %b", e.name, ob.busy, e.busy);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_packet;
        mat_t  sel;
        mat_t  diag;
        snap_t e;
        snap_t ob;
        sel  = '0;
        diag = '0;
        for (int i = 0; i < 5; i++) begin
            sel[i]  = 5'(1 << i);
            diag    = diag | pr(i, i);
        end
        drive("reset",     1'b1, 5'b00000, 5'b00000, 5'b00000, sel, '0);
        drive("all_busy",  1'b0, 5'b11111, 5'b00000, 5'b00000, sel, diag);
        drive("mid_reset", 1'b1, 5'b11111, 5'b11111, 5'b00000, sel, '0);
        drive("regrant",   1'b0, 5'b11111, 5'b00000, 5'b00000, sel, diag);
        drive("rel_all",   1'b0, 5'b11111, 5'b11111, 5'b11111, sel, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ob = obs_q.pop_front();
            total++;
            if (ob.og !== e.og) $display("FAIL midrst/%s out_grant got %h need %h", e.name, ob.og, e.og);
            else passed++;
            total++;
            if (ob.ig !== e.ig) $display("FAIL midrst/%s in_grant got %h need %h", e.name, ob.ig, e.ig);
            else passed++;
            total++;
            if (ob.busy !== e.busy) $display("FAIL midrst/%s out_busy got %b need %b", e.name, ob.busy, e.busy);
            else passed++;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset;
        test_contention;
        test_partial_busy;
        test_back_to_back;
        test_packet;
        test_reset_mid_packet;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
